// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO write and read controllers.
// Holds the default address width and the Gray/binary conversion functions.
// Functions work on a 32-bit word; callers zero-extend in and truncate out.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 3;

  typedef logic [31:0] ptr_word_t;

  // Binary to Gray. Zero-extended inputs give zero-extended results,
  // so the caller can truncate back to any pointer width.
  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary. Each binary bit is the XOR of all Gray bits at and
  // above it. Upper zero bits leave the lower result unaffected.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Latency: 2 destination-clock edges. No backpressure; samples every cycle.
// Ports: clk_i/rst_ni destination clock and async active-low reset,
//        d_i asynchronous input bus, q_o synchronised output bus.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer/flag controller for a dual-clock FIFO memory.
// Latency: write accepted on the edge with wclken=1; read-pointer changes reach flags 3 edges later.
// Backpressure: wclken is gated by a registered, pessimistic wfull; writes while full are dropped and counted.
// Ports: wclk/wrst_n clock and async active-low reset; winc write request;
//        wq_rptr Gray read pointer (read domain); wovf_clr overflow clear;
//        waddr/wclken memory write address/enable; wptr Gray write pointer;
//        wfull, walmost_full, wlevel fill status; woverflow, wovf_count drop stats.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE    = FIFO_ADDRSIZE,
  parameter int AFULL_LEVEL = 6,
  parameter int OVF_W       = 8
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wclken,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow,
  output logic [OVF_W-1:0]    wovf_count
);

  localparam int                PTR_W     = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AFULL_THR = PTR_W'(AFULL_LEVEL);

  logic [ADDRSIZE:0] wq2_rptr;
  logic [ADDRSIZE:0] rbin_s;

  logic [ADDRSIZE:0] wbin_q,  wbin_d;
  logic [ADDRSIZE:0] wptr_q,  wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q, wfull_d;
  logic              walmost_full_q, walmost_full_d;
  logic              woverflow_q, woverflow_d;
  logic [OVF_W-1:0]  wovf_count_q, wovf_count_d;

  logic              accept;
  logic              drop;

  sync_2ff #(
    .WIDTH (PTR_W)
  ) u_rptr_sync (
    .clk_i  (wclk),
    .rst_ni (wrst_n),
    .d_i    (wq_rptr),
    .q_o    (wq2_rptr)
  );

  always_comb begin
    accept         = winc & ~wfull_q;
    drop           = winc &  wfull_q;
    wbin_d         = wbin_q + PTR_W'(accept);
    wptr_d         = PTR_W'(bin2gray(32'(wbin_d)));
    rbin_s         = PTR_W'(gray2bin(32'(wq2_rptr)));
    wlevel_d       = wbin_d - rbin_s;
    // In Gray code, "write is one lap ahead of read" means the two MSBs
    // differ and the rest match.
    wfull_d        = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    walmost_full_d = (wlevel_d >= AFULL_THR);

    // A clear coinciding with a drop keeps that drop: flag=1, count=1.
    woverflow_d  = woverflow_q | drop;
    wovf_count_d = wovf_count_q;
    if (wovf_clr) begin
      woverflow_d  = drop;
      wovf_count_d = OVF_W'(drop);
    end else if (drop && (wovf_count_q != {OVF_W{1'b1}})) begin
      wovf_count_d = wovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
      wovf_count_q   <= '0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
      wovf_count_q   <= wovf_count_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wclken       = accept;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;
  assign wovf_count   = wovf_count_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full: reset, fill, overflow, read release,
// streaming wrap-around and asynchronous reset mid-burst.
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [3:0] wq_rptr;
  logic       wovf_clr;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wclken;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;
  logic [7:0] wovf_count;

  int checks   = 0;
  int failures = 0;

  logic [3:0] gtab [0:15] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  always #5 wclk = ~wclk;

  fifo_wptr_full #(
    .ADDRSIZE    (3),
    .AFULL_LEVEL (6),
    .OVF_W       (8)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq_rptr      (wq_rptr),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wclken       (wclken),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow),
    .wovf_count   (wovf_count)
  );

  task automatic test_reset;
    wrst_n = 1'b0; winc = 1'b0; wq_rptr = 4'd0; wovf_clr = 1'b0;
    repeat (3) @(negedge wclk);
    winc = 1'b1;
    #1;
    checks++; if (wclken !== 1'b1) begin failures++; $display("FAIL reset_wclken got=%b exp=1", wclken); end
    winc = 1'b0;
    #1;
    checks++; if (wclken !== 1'b0) begin failures++; $display("FAIL reset_wclken_low got=%b exp=0", wclken); end
    @(negedge wclk);
    wrst_n = 1'b1;
    @(negedge wclk);
    checks++; if (waddr !== 3'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
    checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL reset_wptr got=%b exp=0000", wptr); end
    checks++; if (wfull !== 1'b0) begin failures++; $display("FAIL reset_wfull got=%b exp=0", wfull); end
    checks++; if (walmost_full !== 1'b0) begin failures++; $display("FAIL reset_walmost got=%b exp=0", walmost_full); end
    checks++; if (wlevel !== 4'd0) begin failures++; $display("FAIL reset_wlevel got=%0d exp=0", wlevel); end
    checks++; if (woverflow !== 1'b0) begin failures++; $display("FAIL reset_woverflow got=%b exp=0", woverflow); end
    checks++; if (wovf_count !== 8'd0) begin failures++; $display("FAIL reset_wovf_count got=%0d exp=0", wovf_count); end
  endtask

  task automatic test_fill;
    @(negedge wclk);
    winc = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge wclk);
      checks++; if (wlevel !== 4'(i)) begin failures++; $display("FAIL fill_wlevel[%0d] got=%0d exp=%0d", i, wlevel, i); end
      checks++; if (walmost_full !== (i >= 6)) begin failures++; $display("FAIL fill_walmost[%0d] got=%b exp=%b", i, walmost_full, (i >= 6)); end
      checks++; if (wfull !== (i == 8)) begin failures++; $display("FAIL fill_wfull[%0d] got=%b exp=%b", i, wfull, (i == 8)); end
      checks++; if (waddr !== 3'(i)) begin failures++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, waddr, i % 8); end
      checks++; if (wptr !== gtab[i]) begin failures++; $display("FAIL fill_wptr[%0d] got=%b exp=%b", i, wptr, gtab[i]); end
      if (i == 8) winc = 1'b0;
    end
    checks++; if (wptr !== 4'b1100) begin failures++; $display("FAIL fill_wptr_final got=%b exp=1100", wptr); end
  endtask

  task automatic test_overflow;
    @(negedge wclk);
    winc = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      #1;
      checks++; if (wclken !== 1'b0) begin failures++; $display("FAIL ovf_wclken[%0d] got=%b exp=0", j, wclken); end
      @(negedge wclk);
      checks++; if (waddr !== 3'd0) begin failures++; $display("FAIL ovf_waddr[%0d] got=%0d exp=0", j, waddr); end
      checks++; if (woverflow !== 1'b1) begin failures++; $display("FAIL ovf_flag[%0d] got=%b exp=1", j, woverflow); end
      checks++; if (wovf_count !== 8'(j)) begin failures++; $display("FAIL ovf_count[%0d] got=%0d exp=%0d", j, wovf_count, j); end
      checks++; if (wlevel !== 4'd8) begin failures++; $display("FAIL ovf_wlevel[%0d] got=%0d exp=8", j, wlevel); end
    end
    winc = 1'b0; wovf_clr = 1'b1;
    @(negedge wclk);
    checks++; if (woverflow !== 1'b0) begin failures++; $display("FAIL ovf_clr_flag got=%b exp=0", woverflow); end
    checks++; if (wovf_count !== 8'd0) begin failures++; $display("FAIL ovf_clr_count got=%0d exp=0", wovf_count); end
    // Clear and drop in the same cycle: the drop survives.
    winc = 1'b1; wovf_clr = 1'b1;
    @(negedge wclk);
    checks++; if (woverflow !== 1'b1) begin failures++; $display("FAIL ovf_clrdrop_flag got=%b exp=1", woverflow); end
    checks++; if (wovf_count !== 8'd1) begin failures++; $display("FAIL ovf_clrdrop_count got=%0d exp=1", wovf_count); end
    // 300 further drops saturate the counter.
    wovf_clr = 1'b0;
    repeat (300) @(negedge wclk);
    checks++; if (wovf_count !== 8'hFF) begin failures++; $display("FAIL ovf_saturate got=%0d exp=255", wovf_count); end
    checks++; if (waddr !== 3'd0) begin failures++; $display("FAIL ovf_sat_waddr got=%0d exp=0", waddr); end
    winc = 1'b0; wovf_clr = 1'b1;
    @(negedge wclk);
    wovf_clr = 1'b0;
    checks++; if (wovf_count !== 8'd0) begin failures++; $display("FAIL ovf_sat_clr got=%0d exp=0", wovf_count); end
  endtask

  task automatic test_read_release;
    wq_rptr = 4'b0011;
    @(negedge wclk);
    checks++; if (wfull !== 1'b1) begin failures++; $display("FAIL rel_edge1_wfull got=%b exp=1", wfull); end
    @(negedge wclk);
    checks++; if (wfull !== 1'b1) begin failures++; $display("FAIL rel_edge2_wfull got=%b exp=1", wfull); end
    @(negedge wclk);
    checks++; if (wfull !== 1'b0) begin failures++; $display("FAIL rel_edge3_wfull got=%b exp=0", wfull); end
    checks++; if (wlevel !== 4'd6) begin failures++; $display("FAIL rel_wlevel got=%0d exp=6", wlevel); end
    checks++; if (walmost_full !== 1'b1) begin failures++; $display("FAIL rel_walmost got=%b exp=1", walmost_full); end
    winc = 1'b1;
    @(negedge wclk);
    checks++; if (wfull !== 1'b0) begin failures++; $display("FAIL rel_w1_wfull got=%b exp=0", wfull); end
    checks++; if (wlevel !== 4'd7) begin failures++; $display("FAIL rel_w1_wlevel got=%0d exp=7", wlevel); end
    checks++; if (waddr !== 3'd1) begin failures++; $display("FAIL rel_w1_waddr got=%0d exp=1", waddr); end
    checks++; if (wptr !== 4'b1101) begin failures++; $display("FAIL rel_w1_wptr got=%b exp=1101", wptr); end
    @(negedge wclk);
    winc = 1'b0;
    checks++; if (wfull !== 1'b1) begin failures++; $display("FAIL rel_w2_wfull got=%b exp=1", wfull); end
    checks++; if (wlevel !== 4'd8) begin failures++; $display("FAIL rel_w2_wlevel got=%0d exp=8", wlevel); end
    checks++; if (waddr !== 3'd2) begin failures++; $display("FAIL rel_w2_waddr got=%0d exp=2", waddr); end
    checks++; if (wptr !== 4'b1111) begin failures++; $display("FAIL rel_w2_wptr got=%b exp=1111", wptr); end
  endtask

  task automatic test_stream;
    wrst_n = 1'b0; winc = 1'b0; wq_rptr = 4'd0;
    @(negedge wclk);
    wrst_n = 1'b1;
    winc = 1'b1;
    // Reader trails the writer by one word; with 3 edges of sync/flag lag
    // the registered level settles at 4.
    for (int k = 1; k <= 20; k++) begin
      @(negedge wclk);
      checks++; if (waddr !== 3'(k)) begin failures++; $display("FAIL stream_waddr[%0d] got=%0d exp=%0d", k, waddr, k % 8); end
      checks++; if (wptr !== gtab[k % 16]) begin failures++; $display("FAIL stream_wptr[%0d] got=%b exp=%b", k, wptr, gtab[k % 16]); end
      checks++; if (wfull !== 1'b0) begin failures++; $display("FAIL stream_wfull[%0d] got=%b exp=0", k, wfull); end
      checks++; if (wlevel !== 4'((k < 4) ? k : 4)) begin failures++; $display("FAIL stream_wlevel[%0d] got=%0d exp=%0d", k, wlevel, (k < 4) ? k : 4); end
      wq_rptr = gtab[(k - 1) % 16];
    end
    winc = 1'b0;
    wq_rptr = gtab[4];
    repeat (3) @(negedge wclk);
    checks++; if (wlevel !== 4'd0) begin failures++; $display("FAIL stream_drain_wlevel got=%0d exp=0", wlevel); end
  endtask

  task automatic test_async_reset;
    wrst_n = 1'b0; winc = 1'b0; wq_rptr = 4'd0;
    @(negedge wclk);
    wrst_n = 1'b1;
    winc = 1'b1;
    repeat (5) @(negedge wclk);
    checks++; if (wlevel !== 4'd5) begin failures++; $display("FAIL arst_pre_wlevel got=%0d exp=5", wlevel); end
    #2;
    wrst_n = 1'b0;
    #1;
    checks++; if (waddr !== 3'd0) begin failures++; $display("FAIL arst_waddr got=%0d exp=0", waddr); end
    checks++; if (wptr !== 4'd0) begin failures++; $display("FAIL arst_wptr got=%b exp=0000", wptr); end
    checks++; if (wlevel !== 4'd0) begin failures++; $display("FAIL arst_wlevel got=%0d exp=0", wlevel); end
    checks++; if (wfull !== 1'b0) begin failures++; $display("FAIL arst_wfull got=%b exp=0", wfull); end
    checks++; if (walmost_full !== 1'b0) begin failures++; $display("FAIL arst_walmost got=%b exp=0", walmost_full); end
    checks++; if (woverflow !== 1'b0) begin failures++; $display("FAIL arst_woverflow got=%b exp=0", woverflow); end
    checks++; if (wovf_count !== 8'd0) begin failures++; $display("FAIL arst_wovf_count got=%0d exp=0", wovf_count); end
    checks++; if (wclken !== 1'b1) begin failures++; $display("FAIL arst_wclken got=%b exp=1", wclken); end
    @(posedge wclk);
    #1;
    checks++; if (waddr !== 3'd0) begin failures++; $display("FAIL arst_hold_waddr got=%0d exp=0", waddr); end
    @(negedge wclk);
    winc = 1'b0;
    wrst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_release();
    test_stream();
    test_async_reset();
    repeat (2) @(negedge wclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
